// File: rtl/perm_selection_sequencer.sv
// Selection-index feeder for the safe permutation generator: sequential sweep or LFSR with
// rejection of out-of-range candidates, presented as a registered valid/ready stream.
// Optional statistics counters are enabled with the PERM_SEL_STATS_EN macro.
module perm_selection_sequencer #(
    parameter int unsigned SEL_WIDTH  = 5,
    parameter int unsigned NUM_PERMS  = 24,
    parameter int unsigned LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    output logic                  sel_valid,
    input  logic                  sel_ready,
    output logic [SEL_WIDTH-1:0]  selection,
    output logic                  epoch_done
`ifdef PERM_SEL_STATS_EN
    ,
    output logic [15:0]           reject_count,
    output logic [15:0]           accept_count
`endif
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                 state_q, state_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [SEL_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   valid_q, valid_d;
    logic                   epoch_q, epoch_d;

    logic                   fb;
    logic [LFSR_WIDTH-1:0]  lfsr_step;
    logic [SEL_WIDTH-1:0]   cand;
    logic                   legal;
    logic                   handshake;
    logic                   evaluate;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1
    assign fb        = lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[LFSR_WIDTH-3] ^
                       lfsr_q[LFSR_WIDTH-4] ^ lfsr_q[LFSR_WIDTH-6];
    assign lfsr_step = {lfsr_q[LFSR_WIDTH-2:0], fb};
    assign cand      = mode ? lfsr_q[SEL_WIDTH-1:0] : cnt_q;
    assign legal     = 32'(cand) < NUM_PERMS;
    assign handshake = valid_q & sel_ready;
    assign evaluate  = (state_q == StFill) | handshake;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        epoch_d = 1'b0;
        if (seed_load) begin
            // Restart wins over a coincident handshake; that index counts as consumed.
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = StFill;
        end else if (evaluate) begin
            if (mode) begin
                lfsr_d = lfsr_step;
            end
            if (legal) begin
                sel_d   = cand;
                valid_d = 1'b1;
                state_d = StHold;
                if (!mode) begin
                    cnt_d = (cnt_q == SEL_WIDTH'(NUM_PERMS - 1)) ? '0 : cnt_q + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
                state_d = StFill;
            end
            if (handshake && !mode && (sel_q == SEL_WIDTH'(NUM_PERMS - 1))) begin
                epoch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            epoch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
        end
    end

    assign sel_valid  = valid_q;
    assign selection  = sel_q;
    assign epoch_done = epoch_q;

`ifdef PERM_SEL_STATS_EN
    logic [15:0] rej_q, rej_d;
    logic [15:0] acc_q, acc_d;

    always_comb begin
        rej_d = rej_q;
        acc_d = acc_q;
        if (seed_load) begin
            rej_d = '0;
            acc_d = '0;
        end else begin
            if (evaluate && mode && !legal && (rej_q != 16'hFFFF)) begin
                rej_d = rej_q + 16'd1;
            end
            if (handshake && (acc_q != 16'hFFFF)) begin
                acc_d = acc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_q <= '0;
            acc_q <= '0;
        end else begin
            rej_q <= rej_d;
            acc_q <= acc_d;
        end
    end

    assign reject_count = rej_q;
    assign accept_count = acc_q;
`endif

endmodule

// File: tb/tb_perm_selection_sequencer.sv
// Scoreboard bench for perm_selection_sequencer: the stimulus side refills an expected-index
// queue from a reference model; a negedge monitor pops and compares on every handshake.
module tb_perm_selection_sequencer;

    localparam int NP = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0;
    logic        sel_ready = 1'b1;
    logic        sel_valid;
    logic [4:0]  selection;
    logic        epoch_done;
`ifdef PERM_SEL_STATS_EN
    logic [15:0] reject_count;
    logic [15:0] accept_count;
`endif

    perm_selection_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .selection  (selection),
        .epoch_done (epoch_done)
`ifdef PERM_SEL_STATS_EN
        ,
        .reject_count (reject_count),
        .accept_count (accept_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference stream: every legal index the consumer will see, in order, after a restart.
    // Returns how many candidates are rejected before the first legal one.
    function automatic int refill(input logic [15:0] seed, input logic m, input int n);
        int l, rej, k, fb, cand;
        l   = (seed == 16'h0) ? 'hACE1 : int'(seed);
        rej = 0;
        k   = 0;
        exp_q.delete();
        while (exp_q.size() < n) begin
            if (m) begin
                cand = l % 32;
                if (cand < NP) exp_q.push_back(cand);
                else if (exp_q.size() == 0) rej++;
                fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
                l  = ((l << 1) | fb) & 'hFFFF;
            end else begin
                exp_q.push_back(k % NP);
                k++;
            end
        end
        return rej;
    endfunction

    // Monitor: rule checks against the previous cycle's sampled inputs and outputs.
    bit have_prev = 0;
    bit p_valid, p_ready, p_seed, p_mode;
    int p_sel;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 0;
        end else begin
            if (have_prev && p_seed) chk("valid_after_seed", int'(sel_valid), 0);
            if (have_prev && p_valid && !p_ready && !p_seed) begin
                chk("hold_valid", int'(sel_valid), 1);
                chk("hold_sel", int'(selection), p_sel);
            end
            if (have_prev)
                chk("epoch", int'(epoch_done),
                    int'(p_valid && p_ready && !p_seed && !p_mode && p_sel == NP - 1));
            if (sel_valid) begin
                chk("sel_range", int'(selection < 5'(NP)), 1);
                if (sel_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: handshake of %0d with no expected index",
                                 selection);
                    end else begin
                        chk("sb_sel", int'(selection), exp_q.pop_front());
                    end
                end
            end
            have_prev = 1;
            p_valid   = sel_valid;
            p_ready   = sel_ready;
            p_seed    = seed_load;
            p_mode    = mode;
            p_sel     = int'(selection);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Restart with a seed/mode and check the cycles until the first valid index.
    task automatic do_seed(input logic [15:0] s, input logic m, input int n);
        int rej, cyc;
        seed_in   = s;
        mode      = m;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        rej = refill(s, m, n);
        chk("valid_low_after_load", int'(sel_valid), 0);
        cyc = 0;
        while (!sel_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk("fill_latency", cyc, rej + 1);
    endtask

    initial begin
        int epochs, cyc;

        // Reset state and first indices from the reset seed
        void'(refill(16'hACE1, 1'b1, 64));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(sel_valid), 0);
        chk("rst_sel", int'(selection), 0);
        chk("rst_epoch", int'(epoch_done), 0);
        rst_n = 1'b1;
        step();
        chk("first_valid", int'(sel_valid), 1);
        chk("first_sel", int'(selection), 1);
        step();
        chk("second_sel", int'(selection), 3);

        // Zero seed while holding with a coincident handshake: restarts at 1, 3
        do_seed(16'h0000, 1'b1, 64);
        chk("zero_seed_sel0", int'(selection), 1);
        step();
        chk("zero_seed_sel1", int'(selection), 3);

        // Seed whose first candidates are out of range
        sel_ready = 1'b0;
        do_seed(16'h001F, 1'b1, 64);
        chk("rej_seed_sel", int'(selection), 16);
`ifdef PERM_SEL_STATS_EN
        chk("reject_count", int'(reject_count), 4);
`endif
        sel_ready = 1'b1;

        // Sequential sweep: one epoch pulse per wrap
        do_seed(16'h1234, 1'b0, 200);
        epochs = 0;
        repeat (30) begin
            step();
            if (epoch_done) epochs++;
        end
        chk("epoch_count", epochs, 1);

        // Long random-mode run with random back-pressure
        do_seed(16'($urandom), 1'b1, 10100);
        repeat (10000) begin
            sel_ready = 1'($urandom);
            step();
        end

        // Mixed phases with random seeds and modes
        for (int ph = 0; ph < 8; ph++) begin
            do_seed(16'($urandom_range(0, 65535)), 1'($urandom), 700);
            repeat (600) begin
                sel_ready = 1'($urandom);
                step();
            end
        end

        // Asynchronous reset while an index is held
        sel_ready = 1'b0;
        do_seed(16'hBEEF, 1'b1, 64);
        chk("pre_reset_valid", int'(sel_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(sel_valid), 0);
        chk("async_rst_sel", int'(selection), 0);
        chk("async_rst_epoch", int'(epoch_done), 0);
        void'(refill(16'hACE1, 1'b1, 64));
        step();
        rst_n = 1'b1;
        sel_ready = 1'b1;
        step();
        chk("post_rst_valid", int'(sel_valid), 1);
        chk("post_rst_sel", int'(selection), 1);
        cyc = 0;
        repeat (20) begin
            step();
            cyc++;
        end
        chk("tail_cycles", cyc, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
